// File: rtl/number_streamer.sv
// number_streamer: loadable operand table streamed out over valid/ready with a last marker.
// Latency: start sampled at edge N -> first beat valid in cycle N+1, done pulse after the final handshake.
// Backpressure: out_valid holds and out_data/out_last stay stable until out_ready accepts each beat.
//
// Ports:
//   clk, reset                 clock (rising edge) and asynchronous active-low reset
//   wr_en, wr_addr, wr_data    table write port, honoured only while idle
//   len, start                 stream request; len clamped to DEPTH, sampled when start is taken in idle
//   busy, done                 busy = not idle; done = one-cycle pulse after the stream completes
//   out_valid/out_ready        beat handshake; out_data = operand, out_last = final beat
//   chk                        running sum of accepted beats (mod 2^DATA_W)
//
// Optional feature: define NUMBER_STREAMER_CHK_EN to build the checksum accumulator;
// otherwise chk is tied to zero and no accumulator is built.

module number_streamer #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [IDX_W:0]    len,
    input  logic              start,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              done,
    output logic [DATA_W-1:0] chk
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    localparam logic [IDX_W:0]   DEPTH_L = (IDX_W+1)'(DEPTH);
    localparam logic [IDX_W:0]   LEN_ONE = (IDX_W+1)'(1);
    localparam logic [IDX_W-1:0] IDX_ONE = (IDX_W)'(1);

    state_t            state_q;
    state_t            state_d;

    logic [DATA_W-1:0] tbl [DEPTH];
    logic [IDX_W-1:0]  idx_q;
    logic [IDX_W:0]    len_q;

    logic [IDX_W:0]    len_clamp;
    logic              start_acc;
    logic              handshake;
    logic              is_last;

    // A request longer than the table simply streams the whole table.
    assign len_clamp = (len > DEPTH_L) ? DEPTH_L : len;
    assign start_acc = (state_q == S_IDLE) && start;

    // out_valid is exactly "in STREAM", so the handshake is derived from state
    // directly rather than from the output process.
    assign handshake = (state_q == S_STREAM) && out_ready;

    // Decoded purely from registered idx/len_q: no path from out_ready to out_last.
    // len_q is never zero while streaming, so len_q-1 cannot underflow there.
    assign is_last   = ({1'b0, idx_q} == (len_q - LEN_ONE));

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    // Zero-length request skips straight to the done pulse.
                    state_d = (len_clamp == '0) ? S_DONE : S_STREAM;
                end
            end
            S_STREAM: begin
                if (handshake && is_last) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------
    always_comb begin
        busy      = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        done      = 1'b0;
        case (state_q)
            S_STREAM: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_data  = tbl[idx_q];
                out_last  = is_last;
            end
            S_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Stream position and latched length
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_q <= '0;
            len_q <= '0;
        end else if (start_acc) begin
            idx_q <= '0;
            len_q <= len_clamp;
        end else if (handshake && !is_last) begin
            idx_q <= idx_q + IDX_ONE;
        end
    end

    // ------------------------------------------------------------------
    // Operand table. Writes land only while idle, so the table is frozen
    // for the duration of a stream. A write coinciding with start is still
    // idle, so the stream that follows sees the new value.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl[i] <= '0;
            end
        end else if ((state_q == S_IDLE) && wr_en) begin
            tbl[wr_addr] <= wr_data;
        end
    end

    // ------------------------------------------------------------------
    // Optional checksum of accepted beats. Cleared when a stream is taken,
    // so it holds its final value from the done cycle until the next start.
    // ------------------------------------------------------------------
`ifdef NUMBER_STREAMER_CHK_EN
    logic [DATA_W-1:0] chk_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            chk_q <= '0;
        end else if (start_acc) begin
            chk_q <= '0;
        end else if (handshake) begin
            chk_q <= chk_q + out_data;
        end
    end

    assign chk = chk_q;
`else
    assign chk = '0;
`endif

endmodule

// File: tb/tb_number_streamer.sv
module tb_number_streamer;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 8;
    localparam int IDX_W  = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              wr_en;
    logic [IDX_W-1:0]  wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [IDX_W:0]    len;
    logic              start;
    logic              busy;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              done;
    logic [DATA_W-1:0] chk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference copy of the operand table.
    logic [DATA_W-1:0] m_tbl [DEPTH];

    number_streamer #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .len       (len),
        .start     (start),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .done      (done),
        .chk       (chk)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic load(input int addr, input int val);
        @(posedge clk); #1;
        wr_en   = 1'b1;
        wr_addr = IDX_W'(addr);
        wr_data = DATA_W'(val);
        @(posedge clk); #1;
        wr_en = 1'b0;
        m_tbl[addr] = DATA_W'(val);
    endtask

    // Starts a stream of n_len entries and scores every cycle until the
    // expected done pulse. mode: 0 ready high, 1 ready pattern 1,0,0, 2 random.
    // poke: mid-stream write to addr 3 plus a second start (both must be ignored).
    // sim_wr: random table write in the same cycle as start (must be seen).
    task automatic run_stream(input string name, input int n_len, input int mode,
                              input bit poke, input bit sim_wr);
        int exp_n;
        int exp_chk;
        int beats;
        int iter;
        int a;
        int v;
        @(posedge clk); #1;
        if (sim_wr) begin
            a = $urandom_range(0, DEPTH-1);
            v = $urandom_range(0, 255);
            wr_en   = 1'b1;
            wr_addr = IDX_W'(a);
            wr_data = DATA_W'(v);
            m_tbl[a] = DATA_W'(v);
        end
        start = 1'b1;
        len   = (IDX_W+1)'(n_len);
        exp_n = (n_len > DEPTH) ? DEPTH : n_len;
        exp_chk = 0;
        for (int i = 0; i < exp_n; i++) exp_chk = (exp_chk + int'(m_tbl[i])) % 256;
`ifndef NUMBER_STREAMER_CHK_EN
        exp_chk = 0;
`endif
        @(posedge clk); #1;
        start = 1'b0;
        wr_en = 1'b0;
        beats = 0;
        iter  = 0;
        while (1) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ((iter % 3) == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (poke && iter == 1) begin
                wr_en   = 1'b1;
                wr_addr = 3'd3;
                wr_data = 8'hAA;
                start   = 1'b1;
                len     = 4'd2;
            end else if (poke) begin
                wr_en = 1'b0;
                start = 1'b0;
            end
            @(negedge clk);
            n_tests++;
            if (busy !== 1'b1) begin
                n_fail++;
                $display("FAIL %s busy iter %0d: got %b expected 1", name, iter, busy);
            end
            n_tests++;
            if (out_valid !== (beats < exp_n)) begin
                n_fail++;
                $display("FAIL %s out_valid iter %0d: got %b expected %b", name, iter, out_valid, beats < exp_n);
            end
            if (beats < exp_n && out_valid === 1'b1) begin
                n_tests++;
                if (out_data !== m_tbl[beats]) begin
                    n_fail++;
                    $display("FAIL %s out_data beat %0d: got %0h expected %0h", name, beats, out_data, m_tbl[beats]);
                end
                n_tests++;
                if (out_last !== (beats == exp_n - 1)) begin
                    n_fail++;
                    $display("FAIL %s out_last beat %0d: got %b expected %b", name, beats, out_last, beats == exp_n - 1);
                end
            end
            n_tests++;
            if (done !== (beats == exp_n)) begin
                n_fail++;
                $display("FAIL %s done iter %0d: got %b expected %b", name, iter, done, beats == exp_n);
            end
            if (beats == exp_n) begin
                n_tests++;
                if (chk !== DATA_W'(exp_chk)) begin
                    n_fail++;
                    $display("FAIL %s chk: got %0h expected %0h", name, chk, exp_chk);
                end
                break;
            end
            if (out_valid === 1'b1 && out_ready) beats++;
            iter++;
            if (iter > 200) begin
                n_tests++;
                n_fail++;
                $display("FAIL %s timeout: %0d beats seen expected %0d", name, beats, exp_n);
                break;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        wr_en = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s idle after done: busy %b done %b valid %b expected 0 0 0", name, busy, done, out_valid);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        len = '0; start = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) m_tbl[i] = '0;
        #12;
        n_tests++;
        if ({busy, out_valid, out_last, done} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset flags: got %b expected 0000", {busy, out_valid, out_last, done});
        end
        n_tests++;
        if (out_data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset out_data: got %0h expected 0", out_data);
        end
        n_tests++;
        if (chk !== 8'h00) begin
            n_fail++;
            $display("FAIL reset chk: got %0h expected 0", chk);
        end
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    task automatic test_basic();
        int vals [7] = '{1, 5, 9, 2, 6, 7, 1};
        for (int i = 0; i < 7; i++) load(i, vals[i]);
        run_stream("basic", 7, 0, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure();
        run_stream("backpressure", 7, 1, 1'b0, 1'b0);
    endtask

    task automatic test_len_zero();
        run_stream("len_zero", 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_wrap();
        for (int i = 0; i < DEPTH; i++) load(i, 255);
        run_stream("wrap", 9, 0, 1'b0, 1'b0);
    endtask

    task automatic test_frozen();
        run_stream("frozen", 7, 0, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        start = 1'b1; len = 4'd7; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        n_tests++;
        if (out_valid !== 1'b1 || out_data !== m_tbl[3]) begin
            n_fail++;
            $display("FAIL reset_mid 4th beat: valid %b data %0h expected 1 %0h", out_valid, out_data, m_tbl[3]);
        end
        reset = 1'b0;
        #1;
        n_tests++;
        if ({busy, out_valid, out_last, done} !== 4'b0000 || out_data !== 8'h00 || chk !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_mid outputs: flags %b data %0h chk %0h expected 0000 0 0",
                     {busy, out_valid, out_last, done}, out_data, chk);
        end
        for (int i = 0; i < DEPTH; i++) m_tbl[i] = '0;
        out_ready = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        run_stream("after_reset", 8, 0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        int nw;
        for (int r = 0; r < 10; r++) begin
            nw = $urandom_range(0, 4);
            for (int w = 0; w < nw; w++) load($urandom_range(0, DEPTH-1), $urandom_range(0, 255));
            run_stream("random", $urandom_range(0, 15), 2, 1'b0, 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_len_zero();
        test_wrap();
        test_frozen();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/number_streamer.md
# number_streamer

Upstream feeder for the summation stage. Holds a small writable table of operands and, on `start`, streams the first `len` entries out over a valid/ready handshake with a `last` marker, so the summer consumes them one per accepted beat. It replaces the hard-coded operand array with a loadable, back-pressurable source.

## Interface

- `DATA_W`, 8, operand width
- `DEPTH`, 8, table entries (power of two, ≥ 2)
- `IDX_W`, $clog2(DEPTH), table index width

- `clk`  in  1  clock, all state on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `wr_en`  in  1  table write strobe
- `wr_addr`  in  IDX_W  table write index
- `wr_data`  in  DATA_W  table write value
- `len`  in  IDX_W+1  number of entries to stream, sampled on `start`
- `start`  in  1  begin a stream (single-cycle pulse or level, sampled only in IDLE)
- `busy`  out  1  high in STREAM and DONE
- `out_valid`  out  1  beat available
- `out_ready`  in  1  downstream accepts beat
- `out_data`  out  DATA_W  current operand
- `out_last`  out  1  current beat is final of stream
- `done`  out  1  one-cycle pulse after stream completes
- `chk`  out  DATA_W  stream checksum (see Configuration)

## Operation

- States: IDLE, STREAM, DONE. Reset → IDLE.
- Table: DEPTH × DATA_W registers, all cleared to 0 by reset.
- Write: `wr_en` in IDLE writes `table[wr_addr] <= wr_data`. `wr_en` in STREAM/DONE ignored (table frozen during a stream).
- Simultaneous `wr_en` and `start` in IDLE: write takes effect; the stream starts in the next cycle, so it sees the new value.
- IDLE, `start`=1: latch `len_q = min(len, DEPTH)`, `idx=0`.
  - `len_q`≠0 → STREAM.
  - `len_q`=0 → DONE (no beats).
- STREAM: `out_valid`=1, `out_data=table[idx]`, `out_last=(idx==len_q-1)`.
  - Handshake = `out_valid & out_ready`. On handshake, not last: `idx++`. On handshake, last: → DONE.
  - No handshake: `idx`, `out_data`, and `out_last` are held stable. `out_valid` never drops mid-stream.
- DONE: `done`=1 for exactly one cycle → IDLE.
- `start` outside IDLE: ignored.
- Reset asserted mid-stream: immediate return to IDLE. Outputs go to reset values. Table cleared.

## Timing

- Reset values: `busy`=0, `out_valid`=0, `out_data`=0, `out_last`=0, `done`=0, `chk`=0.
- `start` sampled at edge N → first beat valid in cycle N+1.
- With `out_ready` held high: one beat per cycle. `len_q` beats occupy cycles N+1..N+len_q; `done` in cycle N+len_q+1.
- `len`=0: `done` in cycle N+1.
- IDLE again at N+len_q+2; next `start` accepted there. Minimum stream-to-stream gap is 1 idle cycle.
- `out_data`, `out_last` decode from registered `idx`/`len_q` (no combinational path from `out_ready`).
- `busy` = state ≠ IDLE.

## Configuration

- `NUMBER_STREAMER_CHK_EN` defined:
  - `chk` is a DATA_W register cleared on `start` acceptance.
  - On each handshake, `chk += out_data`, modulo 2^DATA_W.
  - The value is final and stable from the `done` cycle until the next `start`.
- Undefined: `chk` tied to 0 and no accumulator logic is built.

## Test plan

- Load 1,5,9,2,6,7,1 at addresses 0..6, `len`=7, `out_ready`=1 → beats 1,5,9,2,6,7,1 on consecutive cycles; `out_last` only on the 7th beat; `done` on the following cycle; `chk`=31 (with macro), 0 (without).
- Same load, `out_ready` toggling 1,0,0,1,… → each beat held stable while unaccepted, order unchanged; exactly 7 handshakes, then `done`.
- `len`=0 → `out_valid` never asserted, `done` one cycle after `start`, `busy` high for exactly 1 cycle.
- `len`=9 with all 8 entries set to 0xFF → exactly 8 beats; `chk`=0xF8 (wrap).
- During a stream, `wr_en` to addr 3 with 0xAA and a second `start` → both ignored; streamed beat 3 keeps its old value; no restart.
- Assert `reset` low after 3 beats → `out_valid`, `busy`, `done` low immediately; after release the table reads all 0 (stream `len`=2 yields 0,0).
